// File: rtl/prog_loader_if.sv
// Byte-stream input and memory-write bus for the program loader.
//
// Handshake: a byte moves from master to slave on a rising clock edge where
// both in_valid and in_ready are 1. The master holds in_data stable while
// in_valid is 1 and waits for that edge. in_ready does not depend on
// in_valid. The mem_* signals form a write-only bus. mem_wr pulses for
// exactly one cycle per byte written.
interface prog_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  // Loader side: consumes the stream and drives the memory bus.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr, mem_addr, mem_data
  );

  // Environment side: produces the stream and observes the memory bus.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr, mem_addr, mem_data
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader. It receives a stream of the form LEN, LEN payload bytes
// and CHK. It writes the payload bytes to memory from address 0 upward.
// It releases the CPU from reset only when the byte sum of the payload plus
// CHK is 0 mod 256. dbg_state exposes the FSM state.
module prog_loader #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.slave  bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  localparam int CW    = ADDR_W + 1;             // counter reaches 2**ADDR_W without wrapping
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] len_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sum_q;
  logic [TW-1:0] tmr_q;

  logic          accept;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    sum_nxt;
  logic          tmr_hit;
  logic          len_bad;

  // Ready is decoded from the state so that it never waits on in_valid.
  assign bus.in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cnt_nxt      = cnt_q + CW'(1);
  assign sum_nxt      = sum_q + bus.in_data;
  assign tmr_hit      = !bus.in_valid && (tmr_q == TW'(TIMEOUT - 1));
  assign len_bad      = (bus.in_data == 8'd0) || (int'(bus.in_data) > DEPTH);
  assign dbg_state    = state;

  // Load sequencer. It also registers all outputs except in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      bus.mem_wr   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      tmr_q        <= '0;
    end else begin
      bus.mem_wr <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            bus.mem_addr <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            tmr_q        <= '0;
          end
        end
        LEN, DATA, CSUM: begin
          if (accept) begin
            tmr_q <= '0;
            if (state == LEN) begin
              if (len_bad) begin
                state <= ERR;
                err   <= 1'b1;
              end else begin
                len_q <= CW'(bus.in_data);
                state <= DATA;
              end
            end else if (state == DATA) begin
              bus.mem_wr   <= 1'b1;
              bus.mem_addr <= cnt_q[ADDR_W-1:0];
              bus.mem_data <= bus.in_data;
              sum_q        <= sum_nxt;
              cnt_q        <= cnt_nxt;
              if (cnt_nxt == len_q) state <= CSUM;
            end else begin
              if (sum_nxt == 8'd0) begin
                state   <= DONE;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end else begin
                state <= ERR;
                err   <= 1'b1;
              end
            end
          end else if (tmr_hit) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a stream driver, a memory-write
// scoreboard and a one-line final report.
module tb_prog_loader;

  localparam int AW  = 5;
  localparam int TMO = 20;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpu_rst;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+7:0] exp_q[$];
  logic [7:0]    stream[$];

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  // done and err must never both be 1.
  always @(negedge clk) begin
    chk("done_err_excl", {31'd0, done & err}, 32'd0);
    if (bus.mem_wr) begin
      chk("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("wr_addr_data", {19'd0, bus.mem_addr, bus.mem_data}, {19'd0, exp_q.pop_front()});
    end
  end

  // Driver: presents one byte and holds it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  // Sends the global stream. Payload bytes are queued as expected writes.
  task automatic play_stream(input bit gaps);
    int n;
    n = int'(stream[0]);
    for (int i = 0; i < stream.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i >= 1 && i <= n) exp_q.push_back({AW'(i - 1), stream[i]});
      send_byte(stream[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_good(input int n, input int seed);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      b = 8'(i * 5 + seed);
      stream.push_back(b);
      s = s + b;
    end
    stream.push_back(8'd0 - s);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst_state",   {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    chk("rst_mem_wr",  {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_addr",    {27'd0, bus.mem_addr}, 32'd0);
    chk("rst_data",    {24'd0, bus.mem_data}, 32'd0);
    chk("rst_ready",   {31'd0, bus.in_ready}, 32'd0);

    // Good load: 11+22+33+9A = 0x100.
    pulse_start();
    chk("start_state", {29'd0, dbg_state}, {29'd0, ST_LEN});
    chk("start_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("start_cpu",   {31'd0, cpu_rst}, 32'd1);
    stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    play_stream(1'b0);
    @(negedge clk);
    chk("good_done", {31'd0, done}, 32'd1);
    chk("good_cpu",  {31'd0, cpu_rst}, 32'd0);
    chk("good_err",  {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    chk("good_hold", {31'd0, done}, 32'd1);
    chk("good_drain", exp_q.size(), 32'd0);

    // Bad checksum: 01+02+00 = 3.
    pulse_start();
    chk("restart_cpu",  {31'd0, cpu_rst}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    stream = '{8'h02, 8'h01, 8'h02, 8'h00};
    play_stream(1'b0);
    @(negedge clk);
    chk("csum_err",  {31'd0, err}, 32'd1);
    chk("csum_cpu",  {31'd0, cpu_rst}, 32'd1);
    chk("csum_done", {31'd0, done}, 32'd0);
    chk("csum_drain", exp_q.size(), 32'd0);

    // Bad lengths 00 and 21. No writes may follow.
    pulse_start();
    stream = '{8'h00};
    play_stream(1'b0);
    @(negedge clk);
    chk("len0_err",   {31'd0, err}, 32'd1);
    chk("len0_state", {29'd0, dbg_state}, {29'd0, ST_ERR});
    pulse_start();
    chk("len21_clear", {31'd0, err}, 32'd0);
    send_byte(8'h21);
    @(negedge clk);
    chk("len21_err", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("len21_hold", {31'd0, err}, 32'd1);

    // Full depth: 32 bytes, the last write goes to address 1F.
    pulse_start();
    build_good(32, 3);
    play_stream(1'b0);
    @(negedge clk);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_last_addr", {27'd0, bus.mem_addr}, 32'h1F);
    chk("full_drain", exp_q.size(), 32'd0);

    // Random gaps, and a start pulse in the middle of a load that must be ignored.
    pulse_start();
    build_good(6, 40);
    exp_q.push_back({AW'(0), stream[1]});
    send_byte(stream[0]);
    send_byte(stream[1]);
    pulse_start();
    chk("mid_start_ignored", {29'd0, dbg_state}, {29'd0, ST_DATA});
    for (int i = 2; i < stream.size(); i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i <= 6) exp_q.push_back({AW'(i - 1), stream[i]});
      send_byte(stream[i]);
    end
    @(negedge clk);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_drain", exp_q.size(), 32'd0);

    // Timeout while the FSM is in DATA.
    pulse_start();
    stream = '{8'h04, 8'h01, 8'h02};
    play_stream(1'b0);
    repeat (TMO / 2) @(negedge clk);
    chk("tmo_wait_state", {29'd0, dbg_state}, {29'd0, ST_DATA});
    chk("tmo_wait_err",   {31'd0, err}, 32'd0);
    repeat (TMO) @(negedge clk);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_cpu", {31'd0, cpu_rst}, 32'd1);

    // Reset after the second payload byte, then a good load.
    pulse_start();
    stream = '{8'h04, 8'hA1, 8'hA2};
    play_stream(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("mid_rst_cpu",   {31'd0, cpu_rst}, 32'd1);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (4) @(negedge clk);
    chk("mid_rst_drain", exp_q.size(), 32'd0);
    pulse_start();
    stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    play_stream(1'b1);
    @(negedge clk);
    chk("after_rst_done", {31'd0, done}, 32'd1);
    chk("after_rst_cpu",  {31'd0, cpu_rst}, 32'd0);
    chk("after_rst_drain", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width; program depth is 2**ADDR_W bytes.
REQ-002 Parameter TIMEOUT, default 1000, number of consecutive idle cycles allowed while waiting for a byte.
REQ-003 Port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle pulse; begins a load.
REQ-006 Port in_valid  input  1  the byte on in_data is valid.
REQ-007 Port in_data  input  8  stream byte.
REQ-008 Port in_ready  output  1  the loader accepts a byte this cycle.
REQ-009 Port mem_wr  output  1  memory write strobe, one cycle per byte.
REQ-010 Port mem_addr  output  ADDR_W  memory write address.
REQ-011 Port mem_data  output  8  memory write data.
REQ-012 Port cpu_rst  output  1  holds the CPU in reset.
REQ-013 Port done  output  1  the load completed with a good checksum.
REQ-014 Port err  output  1  the load failed.

Function
REQ-015 The block SHALL accept the stream format LEN byte N, then N payload bytes, then one CHK byte.
REQ-016 A byte SHALL transfer only in a cycle where in_valid=1 and in_ready=1.
REQ-017 The FSM SHALL have exactly the states IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-018 In IDLE, DONE and ERR, start=1 SHALL move the FSM to LEN, clear done/err/address/sum/timer, and set cpu_rst=1 on the next cycle.
REQ-019 in_ready SHALL be 1 only in the LEN, DATA and CSUM states.
REQ-020 In LEN, accepting N=0 or N>2**ADDR_W SHALL go to ERR; otherwise the FSM SHALL latch N and go to DATA.
REQ-021 In DATA, each accepted byte SHALL produce, one cycle later, mem_wr=1 with mem_addr = the byte index (starting at 0) and mem_data = the byte.
REQ-022 In DATA, the running sum SHALL add each accepted byte modulo 256.
REQ-023 After the Nth payload byte, the FSM SHALL go to CSUM.
REQ-024 In CSUM, the block SHALL go to DONE if (sum + CHK) mod 256 == 0, and to ERR otherwise.
REQ-025 The byte counter SHALL be ADDR_W+1 bits wide so that N = 2**ADDR_W does not wrap; mem_addr SHALL never exceed 2**ADDR_W - 1.
REQ-026 DONE SHALL drive done=1 and cpu_rst=0, and SHALL hold until start or rst.
REQ-027 ERR SHALL drive err=1 and cpu_rst=1 (the CPU stays held), and SHALL hold until start or rst; memory already written is not rolled back.
REQ-028 In LEN, DATA or CSUM, TIMEOUT consecutive cycles with in_valid=0 SHALL go to ERR; any accepted byte SHALL reset the idle timer.
REQ-029 start asserted while in LEN, DATA or CSUM SHALL be ignored.
REQ-030 mem_wr SHALL be 0 in every cycle not covered by REQ-021.
REQ-031 done and err SHALL never both be 1.
REQ-032 All outputs SHALL be registered except in_ready, which is decoded from the state.

Reset
REQ-033 rst=1 SHALL force IDLE, cpu_rst=1, done=0, err=0, mem_wr=0, mem_addr=0, mem_data=0, in_ready=0, and clear the counters, sum and timer.
REQ-034 rst during any load SHALL abort it within one cycle; no mem_wr SHALL follow the reset edge.
REQ-035 After reset, cpu_rst SHALL stay 1 until a successful load reaches DONE.

Verification
REQ-036 Good load: start; stream 03,11,22,33,9A -> three writes at addresses 0,1,2 with data 11,22,33; then done=1, cpu_rst=0, err=0.
REQ-037 Bad checksum: stream 02,01,02,00 -> two writes, then err=1, cpu_rst=1, done=0.
REQ-038 Bad length: LEN=00, or LEN=21 with ADDR_W=5 -> err=1 the cycle after LEN is accepted, no mem_wr.
REQ-039 Full depth: LEN=20, 32 bytes, correct CHK -> last write at address 1F, done=1, no wrap to address 0.
REQ-040 Backpressure/timeout: in_valid toggled randomly -> writes unchanged; in_valid held at 0 for TIMEOUT cycles mid-DATA -> err=1.
REQ-041 Reset mid-load: rst after the 2nd payload byte -> IDLE and cpu_rst=1 next cycle, no further mem_wr; a new start with a good stream -> done=1.
